xlr8_dmem_dma: RTL

Block-transfer engine that sits directly upstream of the extended data-memory XB (dmem XB) and drives its register port as a bus master. The AVR programs a start address, length, stride and mode through a small register set. The engine then fills a region with a constant or computes an 8-bit checksum over it, with no per-byte CPU writes. Top-level logic muxes the engine's master port onto the dmem XB bus whenever `busy` is high.

---
 rtl/xlr8_dmem_dma_if.sv | 42 ++++
 rtl/xlr8_dmem_dma.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xlr8_dmem_dma_if.sv
// ---------------------------------------------------------------------------
// xlr8_dmem_dma_if
//
// Register-port bus between the block-transfer engine (master) and the
// extended data-memory XB (slave). It mirrors the AVR data-memory access
// port, so the XB can be fed either from the AVR or from the engine by a
// simple mux outside this block.
//
// Signals:
//   m_ramadr    master -> slave  8  target XB register address
//   m_ramre     master -> slave  1  read strobe
//   m_ramwe     master -> slave  1  write strobe
//   m_dm_sel    master -> slave  1  data-memory select
//   m_dbus_out  master -> slave  8  write data
//   m_dbus_in   slave  -> master 8  read data (valid the cycle after m_ramre)
// ---------------------------------------------------------------------------
interface xlr8_dmem_dma_if;
    logic [7:0] m_ramadr;
    logic       m_ramre;
    logic       m_ramwe;
    logic       m_dm_sel;
    logic [7:0] m_dbus_out;
    logic [7:0] m_dbus_in;

    modport master (
        output m_ramadr,
        output m_ramre,
        output m_ramwe,
        output m_dm_sel,
        output m_dbus_out,
        input  m_dbus_in
    );

    modport slave (
        input  m_ramadr,
        input  m_ramre,
        input  m_ramwe,
        input  m_dm_sel,
        input  m_dbus_out,
        output m_dbus_in
    );
endinterface

// File: rtl/xlr8_dmem_dma.sv
// ---------------------------------------------------------------------------
// xlr8_dmem_dma
//
// Block-transfer engine in front of the extended data-memory XB. The AVR
// programs start address, length, stride, fill value and mode, then writes
// START. The engine loads stride and start address into the XB and then
// either streams a constant into the XB data register (fill) or reads
// LEN bytes back and accumulates an 8-bit wrapping checksum (sum).
// Address advance and wrap are done by the XB itself.
//
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   clken           clock enable; all state holds and master strobes drop
//                   while low
//   dbus_in         AVR write data
//   dbus_out        AVR read data (OR of the read-selected registers)
//   io_out_en       high on any AVR read of a DMA register
//   ramadr, ramre,
//   ramwe, dm_sel   AVR data-memory access port
//   busy            engine owns the dmem XB bus (every state but IDLE)
//   dmem            master port to the dmem XB
//
// AVR register map (addresses are parameters):
//   CTRL   W: bit0 START (self-clearing), bit1 MODE (0 fill, 1 sum),
//             bit6 write-1 clears DONE
//          R: {BUSY, DONE, 4'b0, MODE, 1'b0}
//   LEN    16-bit shift-in, high byte first; reads low byte
//   ADR    16-bit shift-in, high byte first; reads low byte
//   STRIDE 8-bit, resets to 1
//   FILL   8-bit fill value
//   SUM    8-bit checksum, read-only
// ---------------------------------------------------------------------------
module xlr8_dmem_dma #(
    parameter logic [7:0] DMA_CTRL_ADDR    = 8'h00,
    parameter logic [7:0] DMA_LEN_ADDR     = 8'h00,
    parameter logic [7:0] DMA_ADR_ADDR     = 8'h00,
    parameter logic [7:0] DMA_STRIDE_ADDR  = 8'h00,
    parameter logic [7:0] DMA_FILL_ADDR    = 8'h00,
    parameter logic [7:0] DMA_SUM_ADDR     = 8'h00,
    parameter logic [7:0] DMEM_ADRREG_ADDR = 8'h00,
    parameter logic [7:0] DMEM_STRIDE_ADDR = 8'h00,
    parameter logic [7:0] DMEM_DATA_ADDR   = 8'h00
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clken,
    input  logic [7:0]             dbus_in,
    output logic [7:0]             dbus_out,
    output logic                   io_out_en,
    input  logic [7:0]             ramadr,
    input  logic                   ramre,
    input  logic                   ramwe,
    input  logic                   dm_sel,
    output logic                   busy,
    xlr8_dmem_dma_if.master        dmem
);

    // -----------------------------------------------------------------------
    // AVR register decode
    // -----------------------------------------------------------------------
    localparam int NUM_REGS = 6;
    localparam int R_CTRL   = 0;
    localparam int R_LEN    = 1;
    localparam int R_ADR    = 2;
    localparam int R_STRIDE = 3;
    localparam int R_FILL   = 4;
    localparam int R_SUM    = 5;

    localparam logic [7:0] REG_ADDR [0:NUM_REGS-1] = '{
        DMA_CTRL_ADDR, DMA_LEN_ADDR, DMA_ADR_ADDR,
        DMA_STRIDE_ADDR, DMA_FILL_ADDR, DMA_SUM_ADDR
    };

    logic [NUM_REGS-1:0] reg_we;
    logic [NUM_REGS-1:0] reg_re;
    logic [7:0]          reg_rdata [0:NUM_REGS-1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_sel
            logic sel;
            assign sel        = dm_sel && (ramadr == REG_ADDR[gi]);
            assign reg_we[gi] = sel && ramwe;
            assign reg_re[gi] = sel && ramre;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_STR,
        ST_LD_AHI,
        ST_LD_ALO,
        ST_XFER_W,
        ST_RD_ISS,
        ST_RD_CAP,
        ST_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg,   cnt_next;
    logic [7:0]  sum_reg,   sum_next;

    logic [15:0] len_reg;
    logic [15:0] adr_reg;
    logic [7:0]  stride_reg;
    logic [7:0]  fill_reg;
    logic        mode_reg;
    logic        done_reg;

    logic        done_set;
    logic        start;
    logic        cfg_wr_en;

    // Unqualified master outputs from the FSM decode; strobes are gated
    // with clken before they leave the block.
    logic [7:0]  m_adr_c;
    logic        m_re_c;
    logic        m_we_c;
    logic        m_sel_c;
    logic [7:0]  m_dout_c;

    assign busy      = (state_reg != ST_IDLE);
    // Configuration is frozen for the whole transfer so the engine never
    // sees a half-updated LEN/ADR/FILL mid-flight.
    assign cfg_wr_en = !busy;
    assign start     = reg_we[R_CTRL] && dbus_in[0] && !busy;

    // -----------------------------------------------------------------------
    // AVR read path
    // -----------------------------------------------------------------------
    assign reg_rdata[R_CTRL]   = {busy, done_reg, 4'b0000, mode_reg, 1'b0};
    assign reg_rdata[R_LEN]    = len_reg[7:0];
    assign reg_rdata[R_ADR]    = adr_reg[7:0];
    assign reg_rdata[R_STRIDE] = stride_reg;
    assign reg_rdata[R_FILL]   = fill_reg;
    assign reg_rdata[R_SUM]    = sum_reg;

    always_comb begin
        dbus_out = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_re[i]) begin
                dbus_out = dbus_out | reg_rdata[i];
            end
        end
    end

    assign io_out_en = |reg_re;

    // -----------------------------------------------------------------------
    // AVR-programmed registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_reg    <= 16'h0000;
            adr_reg    <= 16'h0000;
            stride_reg <= 8'h01;
            fill_reg   <= 8'h00;
            mode_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else if (clken) begin
            if (cfg_wr_en) begin
                if (reg_we[R_LEN]) begin
                    len_reg <= {len_reg[7:0], dbus_in};
                end
                if (reg_we[R_ADR]) begin
                    adr_reg <= {adr_reg[7:0], dbus_in};
                end
                if (reg_we[R_STRIDE]) begin
                    stride_reg <= dbus_in;
                end
                if (reg_we[R_FILL]) begin
                    fill_reg <= dbus_in;
                end
                if (reg_we[R_CTRL]) begin
                    mode_reg <= dbus_in[1];
                end
            end
            // Completion wins over a simultaneous clear so a finish is
            // never lost.
            if (done_set) begin
                done_reg <= 1'b1;
            end else if (reg_we[R_CTRL] && dbus_in[6]) begin
                done_reg <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 16'h0000;
            sum_reg   <= 8'h00;
        end else if (clken) begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sum_reg   <= sum_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and master port decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sum_next   = sum_reg;
        done_set   = 1'b0;
        m_adr_c    = 8'h00;
        m_re_c     = 1'b0;
        m_we_c     = 1'b0;
        m_sel_c    = 1'b0;
        m_dout_c   = 8'h00;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    sum_next = 8'h00;
                    if (len_reg != 16'h0000) begin
                        cnt_next   = len_reg;
                        state_next = ST_LD_STR;
                    end else begin
                        // Zero-length request completes without touching
                        // the XB.
                        state_next = ST_DONE;
                    end
                end
            end

            ST_LD_STR: begin
                m_sel_c    = 1'b1;
                m_we_c     = 1'b1;
                m_adr_c    = DMEM_STRIDE_ADDR;
                m_dout_c   = stride_reg;
                state_next = ST_LD_AHI;
            end

            // The XB address register shifts in high byte first, same as ours.
            ST_LD_AHI: begin
                m_sel_c    = 1'b1;
                m_we_c     = 1'b1;
                m_adr_c    = DMEM_ADRREG_ADDR;
                m_dout_c   = adr_reg[15:8];
                state_next = ST_LD_ALO;
            end

            ST_LD_ALO: begin
                m_sel_c    = 1'b1;
                m_we_c     = 1'b1;
                m_adr_c    = DMEM_ADRREG_ADDR;
                m_dout_c   = adr_reg[7:0];
                state_next = mode_reg ? ST_RD_ISS : ST_XFER_W;
            end

            ST_XFER_W: begin
                m_sel_c    = 1'b1;
                m_we_c     = 1'b1;
                m_adr_c    = DMEM_DATA_ADDR;
                m_dout_c   = fill_reg;
                cnt_next   = cnt_reg - 16'd1;
                state_next = (cnt_reg > 16'd1) ? ST_XFER_W : ST_DONE;
            end

            ST_RD_ISS: begin
                m_sel_c    = 1'b1;
                m_re_c     = 1'b1;
                m_adr_c    = DMEM_DATA_ADDR;
                state_next = ST_RD_CAP;
            end

            // The XB read data is registered, so it is valid one cycle after
            // the read strobe; select and address are held while capturing.
            ST_RD_CAP: begin
                m_sel_c    = 1'b1;
                m_adr_c    = DMEM_DATA_ADDR;
                sum_next   = sum_reg + dmem.m_dbus_in;
                cnt_next   = cnt_reg - 16'd1;
                state_next = (cnt_reg > 16'd1) ? ST_RD_ISS : ST_DONE;
            end

            ST_DONE: begin
                done_set   = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Strobes must not fire while the clock is disabled, otherwise the XB
    // would see repeated accesses for a single engine step.
    assign dmem.m_ramadr   = m_adr_c;
    assign dmem.m_dbus_out = m_dout_c;
    assign dmem.m_dm_sel   = m_sel_c && clken;
    assign dmem.m_ramwe    = m_we_c  && clken;
    assign dmem.m_ramre    = m_re_c  && clken;

endmodule
